// File: rtl/ram_buffer_alloc_pkg.sv
// Shared types and constants for the RAM buffer allocation controller.
package ram_buffer_alloc_pkg;

    localparam int         ENT_NUM_DEF   = 8;
    localparam int         LINE_BYTES    = 16;
    localparam int         LINE_SHIFT    = $clog2(LINE_BYTES);
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        AR    = 2'd1,
        R     = 2'd2,
        ALLOC = 2'd3
    } state_t;

endpackage

// File: rtl/prio_enc_onehot.sv
// Lowest-set-bit priority encoder: returns the winning bit as one-hot and as an index.
module prio_enc_onehot
    import ram_buffer_alloc_pkg::*;
#(
    parameter int N = ENT_NUM_DEF,
    parameter int W = $clog2(ENT_NUM_DEF)
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = W'(i);
            end
        end
    end

endmodule

// File: rtl/ram_buffer_alloc.sv
// Allocation controller in front of the MXU line buffer: hit -> refcount bump, miss -> AXI fetch + allocate.
// state | meaning: IDLE accept requests | AR read address out | R waiting for data beat | ALLOC one-cycle alloc_en pulse
module ram_buffer_alloc
    import ram_buffer_alloc_pkg::*;
#(
    parameter int ENT_NUM = ENT_NUM_DEF,
    parameter int IDX_W   = 3,
    parameter int AXI_AW  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_vld,
    output logic               req_rdy,
    input  logic [7:0]         req_addr,
    input  logic [3:0]         req_start_byte,
    input  logic [3:0]         req_end_byte,
    input  logic               rel_vld,
    input  logic [IDX_W-1:0]   rel_idx,
    output logic [7:0]         lkup_addr,
    input  logic [ENT_NUM-1:0] addr_match,
    input  logic [ENT_NUM-1:0] ent_free,
    output logic [ENT_NUM-1:0] alloc_en,
    output logic [127:0]       alloc_data,
    output logic [7:0]         alloc_addr,
    output logic [3:0]         alloc_start_byte,
    output logic [3:0]         alloc_end_byte,
    output logic [ENT_NUM-1:0] ent_cnt_inc,
    output logic [ENT_NUM-1:0] ent_cnt_dec,
    output logic               arvalid,
    input  logic               arready,
    output logic [AXI_AW-1:0]  araddr,
    input  logic               rvalid,
    output logic               rready,
    input  logic [127:0]       rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    output logic               err_pulse,
    output logic               busy
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ENT_NUM-1:0]   r_victim_oh;
    logic [7:0]           r_line_addr;
    logic [3:0]           r_line_start;
    logic [3:0]           r_line_end;
    logic [127:0]         r_alloc_data;
    logic [7:0]           r_alloc_addr;
    logic [3:0]           r_alloc_start;
    logic [3:0]           r_alloc_end;
    logic [ENT_NUM-1:0]   r_inc;
    logic [ENT_NUM-1:0]   r_dec;
    logic                 r_err;

    logic [ENT_NUM-1:0]   w_hit_oh;
    logic [IDX_W-1:0]     w_hit_idx;
    logic [ENT_NUM-1:0]   w_free_oh;
    logic [IDX_W-1:0]     w_free_idx;
    logic [ENT_NUM-1:0]   w_rel_oh;
    logic                 w_hit;
    logic                 w_any_free;
    logic                 w_acc;
    logic                 w_miss_acc;
    logic                 w_r_last;
    logic                 w_r_ok;
    logic                 w_r_bad;

    prio_enc_onehot #(.N(ENT_NUM), .W(IDX_W)) u_hit_enc (
        .i_vec    (addr_match),
        .o_onehot (w_hit_oh),
        .o_idx    (w_hit_idx)
    );

    prio_enc_onehot #(.N(ENT_NUM), .W(IDX_W)) u_free_enc (
        .i_vec    (ent_free),
        .o_onehot (w_free_oh),
        .o_idx    (w_free_idx)
    );

    assign w_hit      = |addr_match;
    assign w_any_free = |ent_free;
    assign req_rdy    = (r_state == IDLE) & (w_hit | w_any_free);
    assign w_acc      = req_vld & req_rdy;
    assign w_miss_acc = w_acc & ~w_hit;
    assign w_r_last   = (r_state == R) & rvalid & rlast;
    assign w_r_ok     = w_r_last & (rresp == AXI_RESP_OKAY);
    assign w_r_bad    = w_r_last & (rresp != AXI_RESP_OKAY);

    // Equality decode drops out-of-range release indices without a separate bound check.
    always_comb begin
        w_rel_oh = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            w_rel_oh[i] = rel_vld & (rel_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_miss_acc) w_state_nxt = AR;
            AR:      if (arready) w_state_nxt = R;
            R: begin
                if (w_r_ok)       w_state_nxt = ALLOC;
                else if (w_r_bad) w_state_nxt = IDLE;
            end
            ALLOC:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_victim_oh   <= '0;
            r_line_addr   <= '0;
            r_line_start  <= '0;
            r_line_end    <= '0;
            r_alloc_data  <= '0;
            r_alloc_addr  <= '0;
            r_alloc_start <= '0;
            r_alloc_end   <= '0;
            r_inc         <= '0;
            r_dec         <= '0;
            r_err         <= 1'b0;
        end else begin
            r_inc <= (w_acc & w_hit) ? w_hit_oh : '0;
            r_dec <= w_rel_oh;
            r_err <= w_r_bad;
            if (w_miss_acc) begin
                r_victim_oh  <= w_free_oh;
                r_line_addr  <= req_addr;
                r_line_start <= req_start_byte;
                r_line_end   <= req_end_byte;
            end
            // Entry-facing fields change only on a good fill so they stay valid across errors.
            if (w_r_ok) begin
                r_alloc_data  <= rdata;
                r_alloc_addr  <= r_line_addr;
                r_alloc_start <= r_line_start;
                r_alloc_end   <= r_line_end;
            end
        end
    end

    assign lkup_addr        = req_addr;
    assign arvalid          = (r_state == AR);
    assign rready           = (r_state == R);
    assign busy             = (r_state != IDLE);
    assign araddr           = AXI_AW'({r_line_addr, {LINE_SHIFT{1'b0}}});
    assign alloc_en         = (r_state == ALLOC) ? r_victim_oh : '0;
    assign alloc_data       = r_alloc_data;
    assign alloc_addr       = r_alloc_addr;
    assign alloc_start_byte = r_alloc_start;
    assign alloc_end_byte   = r_alloc_end;
    assign ent_cnt_inc      = r_inc;
    assign ent_cnt_dec      = r_dec;
    assign err_pulse        = r_err;

    a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
        (w_acc && w_hit) |-> $onehot(addr_match));

    a_single_beat: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == R) && rvalid) |-> rlast);

    a_hit_sel: assert property (@(posedge clk) disable iff (!rst_n)
        w_hit |-> |(addr_match & (ENT_NUM'(1) << w_hit_idx)));

    a_victim_sel: assert property (@(posedge clk) disable iff (!rst_n)
        w_any_free |-> |(ent_free & (ENT_NUM'(1) << w_free_idx)));

endmodule

// File: tb/tb_ram_buffer_alloc.sv
// Scoreboard bench for ram_buffer_alloc: expected pulses queued at stimulus time, popped by a negedge monitor.
module tb_ram_buffer_alloc;

    localparam int ENT = 8;
    localparam int IW  = 4;
    localparam int AW  = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_vld;
    logic           req_rdy;
    logic [7:0]     req_addr;
    logic [3:0]     req_start_byte;
    logic [3:0]     req_end_byte;
    logic           rel_vld;
    logic [IW-1:0]  rel_idx;
    logic [7:0]     lkup_addr;
    logic [ENT-1:0] addr_match;
    logic [ENT-1:0] ent_free;
    logic [ENT-1:0] alloc_en;
    logic [127:0]   alloc_data;
    logic [7:0]     alloc_addr;
    logic [3:0]     alloc_start_byte;
    logic [3:0]     alloc_end_byte;
    logic [ENT-1:0] ent_cnt_inc;
    logic [ENT-1:0] ent_cnt_dec;
    logic           arvalid;
    logic           arready;
    logic [AW-1:0]  araddr;
    logic           rvalid;
    logic           rready;
    logic [127:0]   rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           err_pulse;
    logic           busy;

    ram_buffer_alloc #(.ENT_NUM(ENT), .IDX_W(IW), .AXI_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
        .req_start_byte(req_start_byte), .req_end_byte(req_end_byte),
        .rel_vld(rel_vld), .rel_idx(rel_idx), .lkup_addr(lkup_addr),
        .addr_match(addr_match), .ent_free(ent_free),
        .alloc_en(alloc_en), .alloc_data(alloc_data), .alloc_addr(alloc_addr),
        .alloc_start_byte(alloc_start_byte), .alloc_end_byte(alloc_end_byte),
        .ent_cnt_inc(ent_cnt_inc), .ent_cnt_dec(ent_cnt_dec),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .err_pulse(err_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   en;
        logic [7:0]   addr;
        logic [3:0]   sb;
        logic [3:0]   eb;
        logic [127:0] data;
    } alloc_t;

    alloc_t     q_alloc[$];
    logic [7:0] q_inc[$];
    logic [7:0] q_dec[$];
    logic       q_err[$];

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] low_oh(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        alloc_t e;
        if (rst_n) begin
            if (alloc_en !== '0) begin
                if (q_alloc.size() == 0) begin
                    chk("alloc_unexp", 128'(alloc_en), 128'h0);
                end else begin
                    e = q_alloc.pop_front();
                    chk("alloc_en", 128'(alloc_en), 128'(e.en));
                    chk("alloc_addr", 128'(alloc_addr), 128'(e.addr));
                    chk("alloc_sb", 128'(alloc_start_byte), 128'(e.sb));
                    chk("alloc_eb", 128'(alloc_end_byte), 128'(e.eb));
                    chk("alloc_data", alloc_data, e.data);
                end
            end
            if (ent_cnt_inc !== '0) begin
                if (q_inc.size() == 0) chk("inc_unexp", 128'(ent_cnt_inc), 128'h0);
                else                   chk("inc", 128'(ent_cnt_inc), 128'(q_inc.pop_front()));
            end
            if (ent_cnt_dec !== '0) begin
                if (q_dec.size() == 0) chk("dec_unexp", 128'(ent_cnt_dec), 128'h0);
                else                   chk("dec", 128'(ent_cnt_dec), 128'(q_dec.pop_front()));
            end
            if (err_pulse !== 1'b0) begin
                if (q_err.size() == 0) chk("err_unexp", 128'(err_pulse), 128'h0);
                else                   chk("err", 128'(err_pulse), 128'(q_err.pop_front()));
            end
        end
    end

    task automatic chk_queues(input string tag);
        chk({tag, "_q_alloc"}, 128'(q_alloc.size()), 128'h0);
        chk({tag, "_q_inc"},   128'(q_inc.size()),   128'h0);
        chk({tag, "_q_dec"},   128'(q_dec.size()),   128'h0);
        chk({tag, "_q_err"},   128'(q_err.size()),   128'h0);
    endtask

    task automatic do_miss(input logic [7:0] addr, input logic [3:0] sb, input logic [3:0] eb,
                           input logic [127:0] data, input logic [1:0] resp, input logic [7:0] free);
        alloc_t e;
        ent_free = free; addr_match = '0;
        req_addr = addr; req_start_byte = sb; req_end_byte = eb; req_vld = 1'b1;
        #1;
        chk("miss_rdy", 128'(req_rdy), 128'h1);
        chk("miss_lkup", 128'(lkup_addr), 128'(addr));
        if (resp == 2'b00) begin
            e.en = low_oh(free); e.addr = addr; e.sb = sb; e.eb = eb; e.data = data;
            q_alloc.push_back(e);
        end else begin
            q_err.push_back(1'b1);
        end
        tick();
        req_vld = 1'b0;
        chk("miss_arvalid", 128'(arvalid), 128'h1);
        chk("miss_araddr", 128'(araddr), 128'({20'h0, addr, 4'h0}));
        chk("miss_busy", 128'(busy), 128'h1);
        // a hit arriving during the miss must be held off, lookup still follows the request
        req_vld = 1'b1; req_addr = 8'h77; addr_match = 8'h01;
        #1;
        chk("inflight_rdy", 128'(req_rdy), 128'h0);
        chk("inflight_lkup", 128'(lkup_addr), 128'h77);
        tick();
        chk("ar_hold", 128'(arvalid), 128'h1);
        req_vld = 1'b0; addr_match = '0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("ar_drop", 128'(arvalid), 128'h0);
        chk("r_rready", 128'(rready), 128'h1);
        rvalid = 1'b1; rdata = data; rresp = resp; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        chk("r_done", 128'(rready), 128'h0);
        tick();
        chk("miss_idle", 128'(busy), 128'h0);
        chk_queues("miss");
    endtask

    task automatic do_hit(input logic [7:0] addr, input logic [7:0] match, input logic [7:0] free);
        req_addr = addr; addr_match = match; ent_free = free; req_vld = 1'b1;
        #1;
        chk("hit_rdy", 128'(req_rdy), 128'h1);
        q_inc.push_back(low_oh(match));
        tick();
        req_vld = 1'b0; addr_match = '0;
        chk("hit_inc", 128'(ent_cnt_inc), 128'(low_oh(match)));
        chk("hit_noar", 128'(arvalid), 128'h0);
        chk("hit_busy", 128'(busy), 128'h0);
        tick();
        chk("hit_inc_end", 128'(ent_cnt_inc), 128'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_vld = 1'b0; req_addr = '0; req_start_byte = '0; req_end_byte = '0;
        rel_vld = 1'b0; rel_idx = '0; addr_match = '0; ent_free = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        #12;
        chk("rst_arvalid", 128'(arvalid), 128'h0);
        chk("rst_rready", 128'(rready), 128'h0);
        chk("rst_alloc_en", 128'(alloc_en), 128'h0);
        chk("rst_inc", 128'(ent_cnt_inc), 128'h0);
        chk("rst_dec", 128'(ent_cnt_dec), 128'h0);
        chk("rst_err", 128'(err_pulse), 128'h0);
        chk("rst_busy", 128'(busy), 128'h0);
        chk("rst_data", alloc_data, 128'h0);
        chk("rst_addr", 128'(alloc_addr), 128'h0);
        chk("rst_sb", 128'(alloc_start_byte), 128'h0);
        chk("rst_eb", 128'(alloc_end_byte), 128'h0);
        chk("rst_araddr", 128'(araddr), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // first miss into an empty buffer lands in entry 0
        do_miss(8'h10, 4'd2, 4'd9, {16{8'hA5}}, 2'b00, 8'hFF);
        chk("held_addr1", 128'(alloc_addr), 128'h10);

        do_hit(8'h10, 8'h04, 8'hFE);

        // no hit and nowhere to put it: stall while the request is held
        ent_free = 8'h00; addr_match = '0; req_addr = 8'h20; req_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_rdy", 128'(req_rdy), 128'h0);
            tick();
            chk("stall_noar", 128'(arvalid), 128'h0);
        end
        do_miss(8'h20, 4'd4, 4'd15, {16{8'h5A}}, 2'b00, 8'h30);

        // error response: no allocation, previous allocation fields held
        do_miss(8'h33, 4'd1, 4'd3, {4{32'hDEADBEEF}}, 2'b10, 8'h80);
        chk("err_held_addr", 128'(alloc_addr), 128'h20);
        chk("err_held_sb", 128'(alloc_start_byte), 128'd4);
        chk("err_held_eb", 128'(alloc_end_byte), 128'd15);
        chk("err_held_data", alloc_data, {16{8'h5A}});
        do_hit(8'h20, 8'h10, 8'h00);

        // release and hit on the same entry in the same cycle
        req_addr = 8'h10; addr_match = 8'h04; ent_free = 8'h00; req_vld = 1'b1;
        rel_vld = 1'b1; rel_idx = 4'd2;
        q_inc.push_back(8'h04); q_dec.push_back(8'h04);
        tick();
        req_vld = 1'b0; addr_match = '0; rel_vld = 1'b0;
        chk("both_inc", 128'(ent_cnt_inc), 128'h04);
        chk("both_dec", 128'(ent_cnt_dec), 128'h04);

        rel_vld = 1'b1; rel_idx = 4'd9;
        tick();
        rel_vld = 1'b0;
        chk("rel9_dec", 128'(ent_cnt_dec), 128'h0);

        rel_vld = 1'b1; rel_idx = 4'd7; q_dec.push_back(8'h80);
        tick();
        rel_vld = 1'b0;
        chk("rel7_dec", 128'(ent_cnt_dec), 128'h80);
        tick();
        chk("rel_end", 128'(ent_cnt_dec), 128'h0);
        chk_queues("rel");

        // reset while waiting for the data beat
        ent_free = 8'hFF; addr_match = '0; req_addr = 8'h42; req_vld = 1'b1;
        tick();
        req_vld = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("mid_rready", 128'(rready), 128'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rready", 128'(rready), 128'h0);
        chk("arst_arvalid", 128'(arvalid), 128'h0);
        chk("arst_busy", 128'(busy), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 128'(busy), 128'h0);
        do_hit(8'h42, 8'h02, 8'hFF);

        tick();
        chk_queues("final");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
